// File: rtl/sound_i2s_pkg.sv
// Shared types and constants for the I2S receiver.
`timescale 1ns/1ps
package sound_i2s_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_LEFT, RX_RIGHT} i2s_rx_state_t;

  localparam int I2S_DEFAULT_BITS_PER_CHANNEL = 32;
  localparam int I2S_MAX_CHANNEL_WIDTH        = 16;

  // Bit position counter advance, sticking at the top so over-long words stay detectable.
  function automatic logic [5:0] bit_cnt_step(input logic [5:0] cnt);
    return (cnt == 6'd63) ? cnt : cnt + 6'd1;
  endfunction

endpackage

// File: rtl/sound_i2s_rx_sync.sv
// Input synchroniser for the I2S pins plus a registered SCLK rising-edge strobe
// with LRCK/SDATA captured alongside it.
`timescale 1ns/1ps
module sound_i2s_rx_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk_74a,
  input  logic reset_n,
  input  logic i2s_sclk,
  input  logic i2s_lrck,
  input  logic i2s_sdata,
  output logic sclk_rise,
  output logic lrck_smp,
  output logic sdata_smp
);

  // Each stage holds {sclk, lrck, sdata}; index SYNC_STAGES-1 is the settled copy.
  logic [SYNC_STAGES-1:0][2:0] stage_reg;
  logic                        sclk_last_reg;
  logic                        sclk_rise_reg;
  logic                        lrck_smp_reg;
  logic                        sdata_smp_reg;
  logic [2:0]                  settled;

  assign settled = stage_reg[SYNC_STAGES-1];

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      stage_reg     <= '0;
      sclk_last_reg <= 1'b0;
      sclk_rise_reg <= 1'b0;
      lrck_smp_reg  <= 1'b0;
      sdata_smp_reg <= 1'b0;
    end else begin
      stage_reg     <= {stage_reg[SYNC_STAGES-2:0], {i2s_sclk, i2s_lrck, i2s_sdata}};
      sclk_last_reg <= settled[2];
      sclk_rise_reg <= settled[2] & ~sclk_last_reg;
      lrck_smp_reg  <= settled[1];
      sdata_smp_reg <= settled[0];
    end
  end

  assign sclk_rise = sclk_rise_reg;
  assign lrck_smp  = lrck_smp_reg;
  assign sdata_smp = sdata_smp_reg;

endmodule

// File: rtl/sound_i2s_rx.sv
// Philips-I2S receiver: oversamples SCLK/LRCK/SDATA on clk_74a and emits L/R sample pairs.
// Optional saturating error counter enabled by defining SOUND_I2S_RX_ERR_COUNT_EN.
`timescale 1ns/1ps
import sound_i2s_pkg::*;

module sound_i2s_rx #(
  parameter int CHANNEL_WIDTH    = I2S_MAX_CHANNEL_WIDTH,
  parameter int SIGNED_OUTPUT    = 1,
  parameter int BITS_PER_CHANNEL = I2S_DEFAULT_BITS_PER_CHANNEL,
  parameter int SYNC_STAGES      = 3,
  parameter int STALL_CYCLES     = 255
) (
  input  logic                     clk_74a,
  input  logic                     reset_n,
  input  logic                     i2s_sclk,
  input  logic                     i2s_lrck,
  input  logic                     i2s_sdata,
  output logic [CHANNEL_WIDTH-1:0] audio_l,
  output logic [CHANNEL_WIDTH-1:0] audio_r,
  output logic                     sample_valid,
  output logic                     locked,
  output logic                     frame_error,
  output logic [15:0]              frame_error_count
);

  if (CHANNEL_WIDTH > I2S_MAX_CHANNEL_WIDTH || CHANNEL_WIDTH < 1) begin : g_bad_width
    $error("sound_i2s_rx: CHANNEL_WIDTH must be 1..16");
  end
  if (SIGNED_OUTPUT != 0 && SIGNED_OUTPUT != 1) begin : g_bad_signed
    $error("sound_i2s_rx: SIGNED_OUTPUT must be 0 or 1");
  end
  if (SIGNED_OUTPUT == 0 && CHANNEL_WIDTH == I2S_MAX_CHANNEL_WIDTH) begin : g_bad_unsigned
    $error("sound_i2s_rx: unsigned output limited to 15 bits");
  end
  if (BITS_PER_CHANNEL < 16 || BITS_PER_CHANNEL > 63) begin : g_bad_bpc
    $error("sound_i2s_rx: BITS_PER_CHANNEL must be 16..63");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sound_i2s_rx: SYNC_STAGES must be at least 2");
  end

  // Unsigned output skips the sign bit, so capture starts one bit later.
  localparam int                CAP_OFS    = (SIGNED_OUTPUT != 0) ? 0 : 1;
  localparam logic [5:0]        LAST_BIT   = 6'(BITS_PER_CHANNEL - 1);
  localparam int                STALL_W    = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  logic sclk_rise;
  logic lrck_smp;
  logic sdata_smp;

  sound_i2s_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_74a  (clk_74a),
    .reset_n  (reset_n),
    .i2s_sclk (i2s_sclk),
    .i2s_lrck (i2s_lrck),
    .i2s_sdata(i2s_sdata),
    .sclk_rise(sclk_rise),
    .lrck_smp (lrck_smp),
    .sdata_smp(sdata_smp)
  );

  i2s_rx_state_t            state_reg, state_next;
  logic [5:0]               bit_cnt_reg;
  logic                     lrck_prev_reg;
  logic [CHANNEL_WIDTH-1:0] word_reg, word_upd, chan_word;
  logic                     neg_reg, neg_upd;
  logic [CHANNEL_WIDTH-1:0] left_hold_reg;
  logic [STALL_W-1:0]       stall_cnt_reg;
  logic [CHANNEL_WIDTH-1:0] audio_l_reg, audio_r_reg;
  logic                     sample_valid_reg, frame_error_reg;

  logic ws_edge, cnt_ok, stall_hit;
  logic latch_left, emit, err;

  assign ws_edge   = sclk_rise && (lrck_smp != lrck_prev_reg);
  assign cnt_ok    = (bit_cnt_reg == LAST_BIT);
  assign stall_hit = !sclk_rise && (stall_cnt_reg == STALL_LAST);

  // The bit index of every sample (WS edge included) is bit_cnt before it advances.
  always_comb begin
    word_upd = word_reg;
    neg_upd  = neg_reg;
    if (sclk_rise) begin
      for (int b = 0; b < CHANNEL_WIDTH; b++) begin
        if (bit_cnt_reg == 6'(CAP_OFS + CHANNEL_WIDTH - 1 - b)) begin
          word_upd[b] = sdata_smp;
        end
      end
      if (CAP_OFS != 0 && bit_cnt_reg == 6'd0) begin
        neg_upd = sdata_smp;
      end
    end
    chan_word = (CAP_OFS != 0 && neg_upd) ? '0 : word_upd;
  end

  always_comb begin
    state_next = state_reg;
    latch_left = 1'b0;
    emit       = 1'b0;
    err        = 1'b0;
    if (ws_edge) begin
      unique case (state_reg)
        RX_IDLE: begin
          if (!lrck_smp) state_next = RX_LEFT;
        end
        RX_LEFT: begin
          if (lrck_smp && cnt_ok) begin
            state_next = RX_RIGHT;
            latch_left = 1'b1;
          end else begin
            state_next = RX_IDLE;
            err        = 1'b1;
          end
        end
        RX_RIGHT: begin
          if (!lrck_smp && cnt_ok) begin
            state_next = RX_LEFT;
            emit       = 1'b1;
          end else begin
            state_next = RX_IDLE;
            err        = 1'b1;
          end
        end
        default: state_next = RX_IDLE;
      endcase
    end else if (stall_hit) begin
      state_next = RX_IDLE;
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= RX_IDLE;
      bit_cnt_reg      <= '0;
      lrck_prev_reg    <= 1'b0;
      word_reg         <= '0;
      neg_reg          <= 1'b0;
      left_hold_reg    <= '0;
      stall_cnt_reg    <= '0;
      audio_l_reg      <= '0;
      audio_r_reg      <= '0;
      sample_valid_reg <= 1'b0;
      frame_error_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sample_valid_reg <= emit;
      frame_error_reg  <= err;
      if (sclk_rise) begin
        lrck_prev_reg <= lrck_smp;
        bit_cnt_reg   <= ws_edge ? 6'd0 : bit_cnt_step(bit_cnt_reg);
        word_reg      <= ws_edge ? '0 : word_upd;
        neg_reg       <= ws_edge ? 1'b0 : neg_upd;
      end
      // An SCLK edge always reloads, even in the cycle the counter would expire.
      if (sclk_rise) begin
        stall_cnt_reg <= '0;
      end else if (stall_cnt_reg != STALL_LAST) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (latch_left) left_hold_reg <= chan_word;
      if (emit) begin
        audio_l_reg <= left_hold_reg;
        audio_r_reg <= chan_word;
      end
    end
  end

`ifdef SOUND_I2S_RX_ERR_COUNT_EN
  logic [15:0] err_cnt_reg;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_reg <= '0;
    end else if (err && err_cnt_reg != 16'hFFFF) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign frame_error_count = err_cnt_reg;
`else
  assign frame_error_count = 16'h0000;
`endif

  assign audio_l      = audio_l_reg;
  assign audio_r      = audio_r_reg;
  assign sample_valid = sample_valid_reg;
  assign frame_error  = frame_error_reg;
  assign locked       = (state_reg != RX_IDLE);

endmodule

// File: tb/tb_sound_i2s_rx.sv
// Directed bench for sound_i2s_rx: signed (default) and 15-bit unsigned instances share one I2S stream.
`timescale 1ns/1ps
module tb_sound_i2s_rx;

  localparam real CLK_HALF  = 6.734;
  localparam real CLK_PER   = 13.468;
  localparam real SCLK_HALF = 162.76;
  localparam int  SYNC      = 3;

  logic        clk_74a   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        i2s_sclk  = 1'b0;
  logic        i2s_lrck  = 1'b0;
  logic        i2s_sdata = 1'b0;

  logic [15:0] audio_l, audio_r, frame_error_count;
  logic        sample_valid, locked, frame_error;
  logic [14:0] u_audio_l, u_audio_r;
  logic [15:0] u_frame_error_count;
  logic        u_sample_valid, u_locked, u_frame_error;

  sound_i2s_rx u_dut (
    .clk_74a(clk_74a), .reset_n(reset_n),
    .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .audio_l(audio_l), .audio_r(audio_r), .sample_valid(sample_valid),
    .locked(locked), .frame_error(frame_error), .frame_error_count(frame_error_count)
  );

  sound_i2s_rx #(.CHANNEL_WIDTH(15), .SIGNED_OUTPUT(0)) u_dut_u (
    .clk_74a(clk_74a), .reset_n(reset_n),
    .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .audio_l(u_audio_l), .audio_r(u_audio_r), .sample_valid(u_sample_valid),
    .locked(u_locked), .frame_error(u_frame_error), .frame_error_count(u_frame_error_count)
  );

  always #CLK_HALF clk_74a = ~clk_74a;

  typedef struct packed { logic [15:0] l; logic [15:0] r; } smp_t;
  smp_t    q_s[$];
  smp_t    q_u[$];
  int      n_cmp = 0;
  int      n_err = 0;
  int      sv_cnt = 0;
  int      fe_cnt = 0;
  int      exp_fe = 0;
  longint  cyc = 0;
  longint  last_sv_cyc = -1;
  realtime last_rise = 0.0;
  logic    pending_lsb = 1'b0;
  int      nb_r[3] = '{31, 33, 20};

  always @(posedge clk_74a) cyc++;
  always @(posedge i2s_sclk) last_rise = $realtime;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference for the unsigned build: drop the sign bit, clamp negatives to zero.
  function automatic logic [14:0] to_u(input logic [15:0] x);
    return x[15] ? 15'h0000 : x[14:0];
  endfunction

  // Data and word select change while SCLK is low; the receiver samples on the rise.
  task automatic sclk_bit(input logic lr, input logic d);
    i2s_sclk  = 1'b0;
    i2s_lrck  = lr;
    i2s_sdata = d;
    #SCLK_HALF;
    i2s_sclk = 1'b1;
    #SCLK_HALF;
  endtask

  // First edge of a half carries the previous word's LSB, then nbits-1 bits MSB first.
  task automatic send_half(input logic lr, input logic [15:0] sample, input int nbits);
    logic [31:0] w;
    w = {sample, 16'h0000};
    sclk_bit(lr, pending_lsb);
    for (int k = 0; k < nbits - 1; k++) sclk_bit(lr, w[31-k]);
    pending_lsb = w[0];
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic expect_out);
    send_half(1'b0, l, 32);
    send_half(1'b1, r, 32);
    if (expect_out) begin
      q_s.push_back('{l: l, r: r});
      q_u.push_back('{l: l, r: r});
    end
  endtask

  always @(negedge clk_74a) begin
    if (reset_n) begin
      if (frame_error === 1'b1) fe_cnt++;
      if (sample_valid === 1'b1) begin
        smp_t e;
        realtime lat;
        sv_cnt++;
        lat = $realtime - last_rise;
        check("sv_expected", 32'(q_s.size() != 0), 32'd1);
        check("sv_latency", 32'((lat > (SYNC + 1) * CLK_PER) && (lat < (SYNC + 3) * CLK_PER)), 32'd1);
        if (last_sv_cyc >= 0) check("sv_spacing", 32'((cyc - last_sv_cyc) >= 1536), 32'd1);
        last_sv_cyc = cyc;
        if (q_s.size() != 0) begin
          e = q_s.pop_front();
          check("audio_l", 32'(audio_l), 32'(e.l));
          check("audio_r", 32'(audio_r), 32'(e.r));
          $display("sample %0d: L=%h R=%h (expected L=%h R=%h)", sv_cnt, audio_l, audio_r, e.l, e.r);
        end
      end
      if (u_sample_valid === 1'b1) begin
        smp_t e;
        check("u_sv_expected", 32'(q_u.size() != 0), 32'd1);
        if (q_u.size() != 0) begin
          e = q_u.pop_front();
          check("u_audio_l", 32'(u_audio_l), 32'(to_u(e.l)));
          check("u_audio_r", 32'(u_audio_r), 32'(to_u(e.r)));
        end
      end
    end
  end

  initial begin
    logic [15:0] exp_cnt;
`ifdef SOUND_I2S_RX_ERR_COUNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    reset_n = 1'b0;
    repeat (5) @(posedge clk_74a);
    #1;
    check("rst_audio_l", 32'(audio_l), 32'd0);
    check("rst_audio_r", 32'(audio_r), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_err_count", 32'(frame_error_count), 32'd0);
    @(negedge clk_74a);
    reset_n = 1'b1;

    // Basic frame: sample appears at the second LRCK 1->0.
    send_half(1'b1, 16'h0000, 32);
    send_frame(16'h1234, 16'hABCD, 1'b1);
    check("locked_basic", 32'(locked), 32'd1);

    // Ten back-to-back frames.
    for (int i = 0; i < 10; i++) send_frame(16'h0100 + 16'(i), 16'hF000 + 16'(i), 1'b1);
    check("sv_count_burst", 32'(sv_cnt), 32'd10);

    // Malformed right half-frames: short, long, very short.
    for (int e = 0; e < 3; e++) begin
      send_half(1'b0, 16'h1111, 32);
      send_half(1'b1, 16'h2222, nb_r[e]);
      send_half(1'b0, 16'h3333, 32);
      exp_fe++;
      $display("error injection %0d: right bits=%0d locked=%0d errors=%0d", e, nb_r[e], locked, fe_cnt);
      check("locked_after_err", 32'(locked), 32'd0);
      check("fe_pulses", 32'(fe_cnt), 32'(exp_fe));
      send_half(1'b1, 16'h4444, 32);
    end
    check("err_count", 32'(frame_error_count), 32'(exp_cnt));
    send_frame(16'h5A5A, 16'hC3C3, 1'b1);
    check("locked_recover", 32'(locked), 32'd1);

    // SCLK stalls low mid-left word.
    send_half(1'b0, 16'h7777, 10);
    i2s_sclk = 1'b0;
    repeat (300) @(posedge clk_74a);
    #1;
    check("locked_stall", 32'(locked), 32'd0);
    check("fe_stall", 32'(fe_cnt), 32'(exp_fe));
    send_half(1'b0, 16'h7777, 22);
    send_half(1'b1, 16'h6666, 32);
    send_frame(16'h4000, 16'h1234, 1'b1);
    send_frame(16'hC000, 16'h7FFF, 1'b1);
    send_half(1'b0, 16'h0000, 32);
    check("locked_restart", 32'(locked), 32'd1);
    check("sv_count_restart", 32'(sv_cnt), 32'd14);

    // Asynchronous reset in the middle of a right word.
    send_half(1'b1, 16'h5555, 12);
    reset_n = 1'b0;
    #1;
    check("mid_rst_audio_l", 32'(audio_l), 32'd0);
    check("mid_rst_audio_r", 32'(audio_r), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_err_count", 32'(frame_error_count), 32'd0);
    check("mid_rst_u_audio_l", 32'(u_audio_l), 32'd0);
    #50;
    reset_n = 1'b1;
    send_half(1'b1, 16'h5555, 20);
    send_frame(16'hABCD, 16'h1234, 1'b1);
    send_half(1'b0, 16'h0000, 32);
    check("sv_count_final", 32'(sv_cnt), 32'd15);

    repeat (20) @(posedge clk_74a);
    #1;
    check("queue_drained", 32'(q_s.size()), 32'd0);
    check("u_queue_drained", 32'(q_u.size()), 32'd0);
    check("fe_total", 32'(fe_cnt), 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
